// File: rtl/mic1_sequencer.sv
// mic1_sequencer: MIC-1 microprogram sequencer (FETCH/EXEC/WAIT/HALT) with MIR decode.
// Ports: clk, rst_n (async active-low); cs_addr/cs_data control-store read;
// alu_n/alu_z flags; mbr for JMPC; mem_busy memory handshake;
// b_read_enable, c_write_enable, alu_ctrl, mem_write/mem_read/mem_fetch datapath controls;
// halted, illegal status.
// Option: define SEQ_ILLEGAL_TRAP_EN to trap B-field codes 9..15 into a sticky illegal halt.
module mic1_sequencer #(
    parameter int         MBR_WIDTH = 8,
    parameter logic [8:0] HALT_ADDR = 9'h1FF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [8:0]           cs_addr,
    input  logic [35:0]          cs_data,
    input  logic                 alu_n,
    input  logic                 alu_z,
    input  logic [MBR_WIDTH-1:0] mbr,
    input  logic                 mem_busy,
    output logic [8:0]           b_read_enable,
    output logic [8:0]           c_write_enable,
    output logic [7:0]           alu_ctrl,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic                 mem_fetch,
    output logic                 halted,
    output logic                 illegal
);
    typedef enum logic [1:0] {FETCH, EXEC, WAIT, HALT} state_t;
    state_t      state, state_nx;
    logic [8:0]  mpc, mpc_nx, jump;
    logic [35:0] mir;
    logic [7:0]  mbr8;
    logic        bad;
    logic        trap;
    assign mbr8    = 8'(mbr);
    assign bad     = mir[3:0] > 4'd8;
    assign cs_addr = mpc;
    assign halted  = state == HALT;
    // JAMN/JAMZ can only set bit 8; JMPC ORs the low byte with MBR.
    assign jump = {mir[35] | (mir[25] & alu_n) | (mir[24] & alu_z),
                   mir[34:27] | (mir[26] ? mbr8 : 8'h00)};
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign trap = bad;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) illegal <= 1'b0;
        else if (state == EXEC && bad) illegal <= 1'b1;
`else
    assign trap    = 1'b0;
    assign illegal = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        mpc_nx   = mpc;
        case (state)
            FETCH: state_nx = EXEC;
            EXEC: begin
                mpc_nx   = trap ? HALT_ADDR : jump;
                state_nx = (trap || jump == HALT_ADDR) ? HALT :
                           (|mir[6:4] && mem_busy) ? WAIT : FETCH;
            end
            WAIT: state_nx = mem_busy ? WAIT : FETCH;
            HALT: state_nx = HALT;
        endcase
    end
    // Datapath controls are registered on the FETCH edge so they are live only during EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            mpc            <= '0;
            mir            <= '0;
            b_read_enable  <= '0;
            c_write_enable <= '0;
            alu_ctrl       <= '0;
            {mem_write, mem_read, mem_fetch} <= '0;
        end else begin
            state          <= state_nx;
            mpc            <= mpc_nx;
            if (state == FETCH) mir <= cs_data;
            b_read_enable  <= (state == FETCH && cs_data[3:0] <= 4'd8) ? 9'd1 << cs_data[3:0] : '0;
            c_write_enable <= state == FETCH ? cs_data[15:7] : '0;
            alu_ctrl       <= state == FETCH ? cs_data[23:16] : '0;
            {mem_write, mem_read, mem_fetch} <= state == FETCH ? cs_data[6:4] : '0;
        end
    end
endmodule

// File: tb/tb_mic1_sequencer.sv
// tb_mic1_sequencer: directed self-checking bench for mic1_sequencer driven by a small microprogram ROM.
module tb_mic1_sequencer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [8:0]  cs_addr;
    logic [35:0] cs_data;
    logic        alu_n = 0, alu_z = 0, mem_busy = 0;
    logic [7:0]  mbr = 0;
    logic [8:0]  b_read_enable, c_write_enable;
    logic [7:0]  alu_ctrl;
    logic        mem_write, mem_read, mem_fetch, halted, illegal;
    logic [35:0] rom [512];
    int checks = 0, errors = 0;

    mic1_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cs_addr(cs_addr), .cs_data(cs_data),
        .alu_n(alu_n), .alu_z(alu_z), .mbr(mbr), .mem_busy(mem_busy),
        .b_read_enable(b_read_enable), .c_write_enable(c_write_enable), .alu_ctrl(alu_ctrl),
        .mem_write(mem_write), .mem_read(mem_read), .mem_fetch(mem_fetch),
        .halted(halted), .illegal(illegal)
    );

    assign cs_data = rom[cs_addr];
    always #5 clk = ~clk;

    function automatic logic [35:0] mk(logic [8:0] na, logic [2:0] j, logic [7:0] a,
                                       logic [8:0] c, logic [2:0] m, logic [3:0] b);
        return {na, j, a, c, m, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_b"}, b_read_enable, 9'h000);
        check({tag, "_c"}, c_write_enable, 9'h000);
        check({tag, "_alu"}, alu_ctrl, 8'h00);
        check({tag, "_mem"}, {mem_write, mem_read, mem_fetch}, 3'b000);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = '0;
        rom[9'h000] = mk(9'h005, 3'b000, 8'h3C, 9'h008, 3'b000, 4'd4);
        rom[9'h005] = mk(9'h040, 3'b001, 8'h00, 9'h100, 3'b000, 4'd0);
        rom[9'h140] = mk(9'h040, 3'b010, 8'h00, 9'h000, 3'b000, 4'd8);
        rom[9'h040] = mk(9'h000, 3'b100, 8'h00, 9'h003, 3'b000, 4'd1);
        rom[9'h010] = mk(9'h020, 3'b000, 8'h00, 9'h001, 3'b010, 4'd2);
        rom[9'h020] = mk(9'h030, 3'b000, 8'h00, 9'h000, 3'b110, 4'hC);
        rom[9'h030] = mk(9'h1FF, 3'b000, 8'h00, 9'h040, 3'b001, 4'd7);

        step(); step();
        check("rst_addr", cs_addr, 9'h000);
        idle_outputs("rst");
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        @(negedge clk) rst_n = 1;

        step();
        check("e0_b", b_read_enable, 9'h010);
        check("e0_c", c_write_enable, 9'h008);
        check("e0_alu", alu_ctrl, 8'h3C);
        step();
        check("f5_addr", cs_addr, 9'h005);
        idle_outputs("f5");
        step();
        check("e5_b", b_read_enable, 9'h001);
        check("e5_c", c_write_enable, 9'h100);
        alu_z = 1;
        step();
        check("jamz_set", cs_addr, 9'h140);
        alu_z = 0;
        step();
        check("e140_b", b_read_enable, 9'h100);
        step();
        check("jamn_clr", cs_addr, 9'h040);
        mbr = 8'h10;
        step();
        check("e40_b", b_read_enable, 9'h002);
        step();
        check("jmpc", cs_addr, 9'h010);
        mbr = 8'h00;
        step();
        check("rd_read", mem_read, 1'b1);
        check("rd_b", b_read_enable, 9'h004);
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            idle_outputs($sformatf("wait%0d", i));
            check($sformatf("wait%0d_addr", i), cs_addr, 9'h020);
            if (i == 1) mem_busy = 0;
        end
        check("wait_fetch_b", b_read_enable, 9'h000);
        step();
        check("rw_mem", {mem_write, mem_read, mem_fetch}, 3'b110);
        check("ill_b", b_read_enable, 9'h000);
        step();
`ifdef SEQ_ILLEGAL_TRAP_EN
        check("trap_illegal", illegal, 1'b1);
        check("trap_halted", halted, 1'b1);
        check("trap_addr", cs_addr, 9'h1FF);
`else
        check("noTrap_illegal", illegal, 1'b0);
        check("noTrap_addr", cs_addr, 9'h030);
        step();
        check("e30_b", b_read_enable, 9'h080);
        check("e30_fetch", mem_fetch, 1'b1);
        step();
`endif
        for (int i = 0; i < 4; i++) begin
            check($sformatf("halt%0d", i), halted, 1'b1);
            check($sformatf("halt%0d_addr", i), cs_addr, 9'h1FF);
            idle_outputs($sformatf("halt%0d", i));
            step();
        end

        #2 rst_n = 0;
        #1;
        check("rst2_halted", halted, 1'b0);
        check("rst2_addr", cs_addr, 9'h000);
        check("rst2_illegal", illegal, 1'b0);
        @(negedge clk) rst_n = 1;
        step();
        check("re0_b", b_read_enable, 9'h010);
        #2 rst_n = 0;
        #1;
        idle_outputs("midexec");
        @(negedge clk) rst_n = 1;
        step();
        check("re1_b", b_read_enable, 9'h010);
        step();
        check("re1_addr", cs_addr, 9'h005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
